// File: rtl/napot_region_encoder_if.sv
// Request / PMP-write / response bundle for the NAPOT region encoder.
// The master drives requests and accepts responses; the encoder is the slave.
interface napot_region_encoder_if #(
  parameter int NUM_ENTRIES = 16
);
  logic                   req_valid;
  logic                   req_ready;
  logic [4:0]             req_idx;
  logic [31:0]            req_base;
  logic [5:0]             req_size_log2;
  logic [2:0]             req_perm;
  logic                   req_lock;
  logic [NUM_ENTRIES-1:0] entry_locked;
  logic                   wr_en;
  logic [4:0]             wr_idx;
  logic [31:0]            wr_addr;
  logic [7:0]             wr_cfg;
  logic                   resp_valid;
  logic                   resp_ready;
  logic [2:0]             resp_code;

  modport master (
    output req_valid, req_idx, req_base, req_size_log2, req_perm, req_lock,
           entry_locked, resp_ready,
    input  req_ready, wr_en, wr_idx, wr_addr, wr_cfg, resp_valid, resp_code
  );

  modport slave (
    input  req_valid, req_idx, req_base, req_size_log2, req_perm, req_lock,
           entry_locked, resp_ready,
    output req_ready, wr_en, wr_idx, wr_addr, wr_cfg, resp_valid, resp_code
  );
endinterface

// File: rtl/napot_region_encoder.sv
// Turns a (base, log2 size, perm) region request into a NAPOT pmpaddr/pmpcfg
// pair, writes it into the PMP entry file and reports a status code.
module napot_region_encoder #(
  parameter int NUM_ENTRIES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  napot_region_encoder_if.slave bus
);
  typedef enum logic [2:0] {IDLE, CHECK, BUILD, WRITE, RESP} state_e;
  typedef enum logic [2:0] {
    RC_OK    = 3'd0,
    RC_SIZE  = 3'd1,
    RC_ALIGN = 3'd2,
    RC_IDX   = 3'd3,
    RC_LOCK  = 3'd4
  } resp_code_e;

  state_e      state_q;
  resp_code_e  code_q;
  resp_code_e  chk_code;
  logic [4:0]  idx_q;
  logic [31:0] base_q;
  logic [5:0]  size_q;
  logic [2:0]  perm_q;
  logic        lock_q;
  logic [31:0] mask_q;
  logic [4:0]  cnt_q;
  logic        req_ready_q;
  logic        wr_en_q;
  logic [4:0]  wr_idx_q;
  logic [31:0] wr_addr_q;
  logic [7:0]  wr_cfg_q;
  logic        resp_valid_q;
  logic [2:0]  resp_code_q;
  logic [31:0] locked_pad;
  logic [63:0] align_mask;

  // Zero-extend the lock vector so any 5-bit index is a legal select.
  assign locked_pad = 32'(bus.entry_locked);
  assign align_mask = (64'd1 << size_q) - 64'd1;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    chk_code = RC_OK;
    if ({1'b0, idx_q} >= 6'(NUM_ENTRIES))                chk_code = RC_IDX;
    else if (locked_pad[idx_q])                          chk_code = RC_LOCK;
    else if (size_q < 6'd3 || size_q > 6'd32)            chk_code = RC_SIZE;
    else if ((64'(base_q) & align_mask) != 64'd0)        chk_code = RC_ALIGN;
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      code_q       <= RC_OK;
      idx_q        <= '0;
      base_q       <= '0;
      size_q       <= '0;
      perm_q       <= '0;
      lock_q       <= 1'b0;
      mask_q       <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      wr_en_q      <= 1'b0;
      wr_idx_q     <= '0;
      wr_addr_q    <= '0;
      wr_cfg_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_code_q  <= '0;
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.req_valid && req_ready_q) begin
            idx_q       <= bus.req_idx;
            base_q      <= bus.req_base;
            size_q      <= bus.req_size_log2;
            perm_q      <= bus.req_perm;
            lock_q      <= bus.req_lock;
            req_ready_q <= 1'b0;
            state_q     <= CHECK;
          end
        end
        CHECK: begin
          code_q <= chk_code;
          mask_q <= '0;
          cnt_q  <= 5'(size_q - 6'd3);
          // Rejected requests spend the WRITE slot with the strobe held low,
          // so every response leaves from the same place.
          state_q <= (chk_code == RC_OK) ? BUILD : WRITE;
        end
        BUILD: begin
          if (cnt_q == 5'd0) begin
            wr_en_q   <= 1'b1;
            wr_idx_q  <= idx_q;
            wr_addr_q <= (base_q >> 2) | mask_q;
            wr_cfg_q  <= {lock_q, 2'b00, 2'b11, perm_q};
            state_q   <= WRITE;
          end else begin
            mask_q <= (mask_q << 1) | 32'd1;
            cnt_q  <= cnt_q - 5'd1;
          end
        end
        WRITE: begin
          resp_valid_q <= 1'b1;
          resp_code_q  <= code_q;
          state_q      <= RESP;
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.wr_en      = wr_en_q;
  assign bus.wr_idx     = wr_idx_q;
  assign bus.wr_addr    = wr_addr_q;
  assign bus.wr_cfg     = wr_cfg_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_code  = resp_code_q;
endmodule

// File: tb/tb_napot_region_encoder.sv
// Randomized and directed bench for napot_region_encoder against an
// arithmetic model of the NAPOT encoding, error priority and latency.
module tb_napot_region_encoder;
  localparam int N = 16;

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] base;
    logic [5:0]  sz;
    logic [2:0]  perm;
    logic        lock;
  } req_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  logic [N-1:0] locked_v = '0;

  napot_region_encoder_if #(.NUM_ENTRIES(N)) bus ();
  napot_region_encoder #(.NUM_ENTRIES(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic void model(input req_t r, input logic [N-1:0] lk, output int code,
                                output logic [31:0] addr, output logic [7:0] cfg,
                                output int wr_cyc, output int resp_cyc);
    longint unsigned span, b;
    span = 64'd1 << r.sz;
    b    = 64'(r.base);
    if (int'(r.idx) >= N)              code = 3;
    else if (lk[r.idx[3:0]])           code = 4;
    else if (r.sz < 3 || r.sz > 32)    code = 1;
    else if (b % span != 0)            code = 2;
    else                               code = 0;
    addr     = 32'(b / 4 + span / 8 - 1);
    cfg      = 8'(int'(r.lock) * 128 + 24 + int'(r.perm));
    wr_cyc   = (int'(r.sz) - 3) + 2;
    resp_cyc = (code == 0) ? (int'(r.sz) - 3) + 3 : 2;
  endfunction

  task automatic drive(input req_t r);
    bus.req_idx       = r.idx;
    bus.req_base      = r.base;
    bus.req_size_log2 = r.sz;
    bus.req_perm      = r.perm;
    bus.req_lock      = r.lock;
    bus.entry_locked  = locked_v;
  endtask

  task automatic do_txn(input req_t r, input int hold, input bit chain, input req_t nxt,
                        input string name);
    int code, wr_cyc, resp_cyc, cyc, n_wr, got_wr_cyc, got_resp_cyc, waited;
    logic [31:0] addr, got_addr;
    logic [7:0]  cfg, got_cfg;
    logic [4:0]  got_idx;
    model(r, locked_v, code, addr, cfg, wr_cyc, resp_cyc);
    drive(r);
    bus.req_valid = 1'b1;
    waited = 0;
    while (bus.req_ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1; waited++;
    end
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL %s_ready_timeout got=%b want=1", name, bus.req_ready);
      bus.req_valid = 1'b0; return;
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    checks++;
    if (bus.req_ready !== 1'b0) begin
      failures++; $display("FAIL %s_accept req_ready got=%b want=0", name, bus.req_ready);
    end
    cyc = 0; n_wr = 0; got_wr_cyc = -1; got_resp_cyc = -1;
    got_idx = '0; got_addr = '0; got_cfg = '0;
    while (got_resp_cyc < 0 && cyc < 100) begin
      if (bus.wr_en === 1'b1) begin
        n_wr++; got_wr_cyc = cyc;
        got_idx = bus.wr_idx; got_addr = bus.wr_addr; got_cfg = bus.wr_cfg;
      end
      if (bus.resp_valid === 1'b1) got_resp_cyc = cyc;
      else begin @(posedge clk); #1; cyc++; end
    end
    checks++;
    if (got_resp_cyc != resp_cyc) begin
      failures++; $display("FAIL %s_resp_latency got=%0d want=%0d", name, got_resp_cyc, resp_cyc);
    end
    checks++;
    if (bus.resp_code !== 3'(code)) begin
      failures++; $display("FAIL %s_resp_code got=%0d want=%0d", name, bus.resp_code, code);
    end
    checks++;
    if (n_wr != ((code == 0) ? 1 : 0)) begin
      failures++; $display("FAIL %s_wr_pulses got=%0d want=%0d", name, n_wr, (code == 0) ? 1 : 0);
    end
    if (code == 0) begin
      checks++;
      if (got_wr_cyc != wr_cyc) begin
        failures++; $display("FAIL %s_wr_latency got=%0d want=%0d", name, got_wr_cyc, wr_cyc);
      end
      checks++;
      if ({got_idx, got_addr, got_cfg} !== {r.idx, addr, cfg}) begin
        failures++;
        $display("FAIL %s_wr_data got idx=%0d addr=%h cfg=%h want idx=%0d addr=%h cfg=%h",
                 name, got_idx, got_addr, got_cfg, r.idx, addr, cfg);
      end
      checks++;
      if (bus.wr_addr !== addr || bus.wr_cfg !== cfg) begin
        failures++; $display("FAIL %s_wr_hold got addr=%h cfg=%h want addr=%h cfg=%h",
                             name, bus.wr_addr, bus.wr_cfg, addr, cfg);
      end
    end
    for (int i = 0; i < hold; i++) begin
      if (chain && i == 0) begin
        drive(nxt);
        bus.req_valid = 1'b1;
      end
      @(posedge clk); #1;
      checks++;
      if ({bus.resp_valid, bus.resp_code, bus.req_ready, bus.wr_en} !== {1'b1, 3'(code), 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL %s_hold%0d got valid=%b code=%0d ready=%b wr_en=%b want valid=1 code=%0d ready=0 wr_en=0",
                 name, i, bus.resp_valid, bus.resp_code, bus.req_ready, bus.wr_en, code);
      end
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    checks++;
    if ({bus.resp_valid, bus.req_ready, bus.resp_code} !== {1'b0, 1'b1, 3'(code)}) begin
      failures++;
      $display("FAIL %s_handshake got valid=%b ready=%b code=%0d want valid=0 ready=1 code=%0d",
               name, bus.resp_valid, bus.req_ready, bus.resp_code, code);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.wr_en, bus.wr_idx, bus.wr_addr, bus.wr_cfg, bus.resp_valid, bus.resp_code, bus.req_ready}
        !== {1'b0, 5'd0, 32'd0, 8'd0, 1'b0, 3'd0, 1'b1}) begin
      failures++;
      $display("FAIL reset_outputs got wr_en=%b idx=%0d addr=%h cfg=%h rv=%b code=%0d ready=%b want 0s and ready=1",
               bus.wr_en, bus.wr_idx, bus.wr_addr, bus.wr_cfg, bus.resp_valid, bus.resp_code, bus.req_ready);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL reset_release_ready got=%b want=1", bus.req_ready);
    end
  endtask

  task automatic test_basic();
    do_txn('{idx:5'd2, base:32'h8000_0000, sz:6'd12, perm:3'b011, lock:1'b0}, 0, 1'b0, '0, "basic");
  endtask

  task automatic test_size_bounds();
    do_txn('{idx:5'd0, base:32'h0000_1000, sz:6'd3, perm:3'b001, lock:1'b0}, 0, 1'b0, '0, "size_min");
    do_txn('{idx:5'd15, base:32'h0000_0000, sz:6'd32, perm:3'b111, lock:1'b1}, 0, 1'b0, '0, "size_max");
  endtask

  task automatic test_errors();
    do_txn('{idx:5'd1, base:32'h8000_0800, sz:6'd12, perm:3'b011, lock:1'b0}, 0, 1'b0, '0, "err_align");
    do_txn('{idx:5'd1, base:32'h0000_0000, sz:6'd2,  perm:3'b011, lock:1'b0}, 0, 1'b0, '0, "err_size_lo");
    do_txn('{idx:5'd1, base:32'h0000_0000, sz:6'd33, perm:3'b011, lock:1'b0}, 0, 1'b0, '0, "err_size_hi");
    do_txn('{idx:5'd16, base:32'h0000_0000, sz:6'd12, perm:3'b011, lock:1'b0}, 0, 1'b0, '0, "err_idx");
    locked_v = 16'h0020;
    do_txn('{idx:5'd5, base:32'h0000_0804, sz:6'd12, perm:3'b011, lock:1'b0}, 0, 1'b0, '0, "err_lock");
    locked_v = '0;
  endtask

  task automatic test_back_to_back();
    req_t a, b;
    a = '{idx:5'd3, base:32'h4000_0000, sz:6'd16, perm:3'b101, lock:1'b0};
    b = '{idx:5'd4, base:32'h2000_0100, sz:6'd8,  perm:3'b110, lock:1'b1};
    do_txn(a, 5, 1'b1, b, "b2b_first");
    do_txn(b, 0, 1'b0, '0, "b2b_second");
  endtask

  task automatic test_reset_midop();
    req_t r;
    int n_wr;
    r = '{idx:5'd1, base:32'h0010_0000, sz:6'd20, perm:3'b101, lock:1'b0};
    drive(r);
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_wr = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (bus.wr_en === 1'b1) n_wr++;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.wr_en, bus.wr_idx, bus.wr_addr, bus.wr_cfg, bus.resp_valid, bus.resp_code}
        !== {1'b0, 5'd0, 32'd0, 8'd0, 1'b0, 3'd0}) begin
      failures++;
      $display("FAIL midop_reset_outputs got wr_en=%b idx=%0d addr=%h cfg=%h rv=%b code=%0d want all 0",
               bus.wr_en, bus.wr_idx, bus.wr_addr, bus.wr_cfg, bus.resp_valid, bus.resp_code);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.req_ready !== 1'b1) begin
      failures++; $display("FAIL midop_ready_after_release got=%b want=1", bus.req_ready);
    end
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.wr_en === 1'b1 || bus.resp_valid === 1'b1) n_wr++;
    end
    checks++;
    if (n_wr != 0) begin
      failures++; $display("FAIL midop_no_write got=%0d events want=0", n_wr);
    end
    do_txn(r, 1, 1'b0, '0, "midop_next");
  endtask

  task automatic test_random();
    req_t r;
    for (int i = 0; i < 24; i++) begin
      locked_v = N'($urandom & $urandom & $urandom);
      r.idx  = 5'($urandom_range(0, 19));
      r.sz   = 6'($urandom_range(0, 35));
      r.perm = 3'($urandom);
      r.lock = 1'($urandom);
      r.base = $urandom;
      if ($urandom_range(0, 9) < 7) begin
        if (r.sz >= 6'd32) r.base = '0;
        else r.base = r.base & ~((32'd1 << r.sz) - 32'd1);
      end
      do_txn(r, int'($urandom_range(0, 3)), 1'b0, '0, "random");
    end
    locked_v = '0;
  endtask

  initial begin
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b0;
    drive('0);
    test_reset();
    test_basic();
    test_size_bounds();
    test_errors();
    test_back_to_back();
    test_reset_midop();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
